data_reader: RTL and testbench
==============================

DATA_READER -- requirements
Module: data_reader

Interface
REQ-001 Parameter ADDR_W, default 18: memory address width; SHALL size Addr and memory_size.
REQ-002 Parameter DATA_W, default 8: byte width; SHALL size Din and Tx_data.
REQ-003 Port clk, input, 1: the only clock; all state SHALL update on the rising edge of clk.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port start, input, 1: request to dump memory; sampled only in IDLE.
REQ-006 Port memory_size, input, ADDR_W: index of the last byte to send; addresses 0..memory_size inclusive.
REQ-007 Port Din, input, DATA_W: memory read data, valid one clk after Ren.
REQ-008 Port Tx_busy, input, 1: UART transmitter busy flag, high while a byte is shifting out.
REQ-009 Port Addr, output, ADDR_W: memory read address.
REQ-010 Port Ren, output, 1: memory read enable, one-cycle pulse per byte.
REQ-011 Port Tx_data, output, DATA_W: byte presented to the transmitter.
REQ-012 Port Tx_start, output, 1: one-cycle pulse requesting transmission of Tx_data.
REQ-013 Port fin, output, 1: level, high after a complete dump, low while a dump is in progress.

Function
REQ-014 The FSM SHALL have the states IDLE, RD_WAIT, LOAD, ACK, DRAIN and DONE.
REQ-015 IDLE, start=1: latch memory_size into size_q, Addr<=0, Ren<=1, fin<=0, go to RD_WAIT; start=0: hold all outputs.
REQ-016 RD_WAIT: Ren<=0, go to LOAD; memory read latency is exactly 1 clk.
REQ-017 LOAD: Tx_data<=Din, Tx_start<=1, go to ACK.
REQ-018 ACK: Tx_start<=0; stay until Tx_busy=1, then go to DRAIN.
REQ-019 DRAIN: stay until Tx_busy=0; then if Addr==size_q go to DONE, else Addr<=Addr+1, Ren<=1, go to RD_WAIT.
REQ-020 DONE: fin<=1, Addr<=0, go to IDLE; fin SHALL remain 1 until the next accepted start.
REQ-021 Tx_start SHALL never be high for more than 1 clk, and SHALL never be high while Tx_busy=1.
REQ-022 Ren SHALL pulse exactly size_q+1 times per dump, at strictly increasing Addr values 0..size_q.
REQ-023 Addr SHALL never exceed size_q and SHALL never wrap; memory_size = 2^ADDR_W-1 is legal.
REQ-024 memory_size=0 SHALL send exactly one byte, from address 0.
REQ-025 start pulses outside IDLE SHALL be ignored; changes to memory_size during a dump SHALL have no effect because size_q is used.
REQ-026 start held high continuously SHALL start a new dump on the cycle after DONE returns the FSM to IDLE.
REQ-027 Unused state encodings SHALL return the FSM to IDLE on the next clk.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, Addr=0, Ren=0, Tx_start=0, Tx_data=0, fin=0 and size_q=0, with no clk edge required.
REQ-029 rst asserted mid-dump SHALL abort the dump with no further Ren or Tx_start; the next dump SHALL begin at Addr=0.

Verification
REQ-030 The bench SHALL cover: memory 0..3 = A5,3C,FF,00, memory_size=3, start pulse, transmitter model busy 10 clk per byte -> Tx_data sequence A5,3C,FF,00, 4 Tx_start pulses, then fin=1 and Addr=0.
REQ-031 The bench SHALL cover: memory_size=0, mem[0]=7E -> one Ren at Addr 0, one Tx_start with Tx_data=7E, then fin=1.
REQ-032 The bench SHALL cover: Tx_busy delayed 3 clk after Tx_start -> FSM holds in ACK, no second Tx_start, Addr unchanged.
REQ-033 The bench SHALL cover: a start pulse while in DRAIN, and memory_size changed 3->1 mid-dump -> both ignored, 4 bytes sent.
REQ-034 The bench SHALL cover: rst asserted asynchronously during the byte 2 ACK -> all outputs 0 before the next clk edge; a new start resends from Addr 0.
REQ-035 The bench SHALL cover: start held high for 2 dumps of memory_size=1 -> 4 bytes sent, fin high for exactly 1 clk between the dumps.

Source files
------------

// File: rtl/data_reader.sv
// Memory dump reader: walks addresses 0..memory_size of a synchronous-read
// memory and hands each byte to a UART transmitter, one byte per
// start/busy handshake. fin reports a completed dump.
module data_reader #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] memory_size,
  input  logic [DATA_W-1:0] Din,
  input  logic              Tx_busy,
  output logic [ADDR_W-1:0] Addr,
  output logic              Ren,
  output logic [DATA_W-1:0] Tx_data,
  output logic              Tx_start,
  output logic              fin
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    LOAD    = 3'd2,
    ACK     = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ren_q, ren_d;
  logic [DATA_W-1:0] txData_q, txData_d;
  logic              txStart_q, txStart_d;
  logic              fin_q, fin_d;

  // State and output registers; reset clears everything without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      size_q    <= '0;
      addr_q    <= '0;
      ren_q     <= 1'b0;
      txData_q  <= '0;
      txStart_q <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      ren_q     <= ren_d;
      txData_q  <= txData_d;
      txStart_q <= txStart_d;
      fin_q     <= fin_d;
    end
  end

  // Next-state logic; Ren and Tx_start default low so they can only ever pulse.
  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    addr_d    = addr_q;
    ren_d     = 1'b0;
    txData_d  = txData_q;
    txStart_d = 1'b0;
    fin_d     = fin_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          size_d  = memory_size;
          addr_d  = '0;
          ren_d   = 1'b1;
          fin_d   = 1'b0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        state_d = LOAD;
      end
      LOAD: begin
        txData_d  = Din;
        txStart_d = 1'b1;
        state_d   = ACK;
      end
      ACK: begin
        if (Tx_busy) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!Tx_busy) begin
          if (addr_q == size_q) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            ren_d   = 1'b1;
            state_d = RD_WAIT;
          end
        end
      end
      DONE: begin
        fin_d   = 1'b1;
        addr_d  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Addr     = addr_q;
  assign Ren      = ren_q;
  assign Tx_data  = txData_q;
  assign Tx_start = txStart_q;
  assign fin      = fin_q;

endmodule

// File: tb/tb_data_reader.sv
// Self-checking bench for data_reader: memory and UART transmitter models,
// an expected-read/expected-byte scoreboard, directed cases and random dumps.
module tb_data_reader;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] memory_size = '0;
  logic [DW-1:0] Din = '0;
  logic          Tx_busy = 1'b0;
  logic [AW-1:0] Addr;
  logic          Ren;
  logic [DW-1:0] Tx_data;
  logic          Tx_start;
  logic          fin;

  int total = 0;
  int bad = 0;

  logic [7:0]    mem [0:15];
  int            txDelay = 0;
  int            busyLen = 10;
  logic [AW-1:0] expAddrQ[$];
  logic [7:0]    expByteQ[$];
  logic [7:0]    sentLog[$];
  int            txCount = 0;
  int            renCount = 0;
  logic          prevTxStart = 1'b0;
  int            delayCnt = 0;
  int            busyCnt = 0;

  data_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .memory_size(memory_size),
    .Din(Din), .Tx_busy(Tx_busy), .Addr(Addr), .Ren(Ren),
    .Tx_data(Tx_data), .Tx_start(Tx_start), .fin(fin)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data valid one clock after Ren, garbage otherwise.
  always @(posedge clk) begin
    if (Ren) Din <= mem[Addr];
    else     Din <= 8'($urandom);
  end

  // Transmitter: busy for busyLen clocks, starting txDelay clocks after Tx_start.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        delayCnt = 0;
        busyCnt  = 0;
        Tx_busy <= 1'b0;
      end else begin
        if (busyCnt > 0) busyCnt--;
        if (delayCnt > 0) begin
          delayCnt--;
          if (delayCnt == 0) busyCnt = busyLen;
        end
        if (Tx_start) begin
          if (txDelay == 0) busyCnt = busyLen;
          else delayCnt = txDelay;
        end
        Tx_busy <= (busyCnt > 0);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every read and every transmitted byte must match the next expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prevTxStart = 1'b0;
      end else begin
        if (Ren) begin
          renCount++;
          if (expAddrQ.size() == 0) checkOutput("ren_unexpected", 32'(Ren), 0);
          else checkOutput("ren_addr", 32'(Addr), 32'(expAddrQ.pop_front()));
          checkOutput("fin_low_on_read", 32'(fin), 0);
        end
        if (Tx_start) begin
          txCount++;
          sentLog.push_back(Tx_data);
          checkOutput("txstart_width", 32'(prevTxStart), 0);
          checkOutput("txstart_vs_busy", 32'(Tx_busy), 0);
          if (expByteQ.size() == 0) checkOutput("tx_unexpected", 32'(Tx_start), 0);
          else checkOutput("tx_data", 32'(Tx_data), 32'(expByteQ.pop_front()));
        end
        prevTxStart = Tx_start;
      end
    end
  end

  task automatic pushExpected(input int size);
    for (int i = 0; i <= size; i++) begin
      expAddrQ.push_back(AW'(i));
      expByteQ.push_back(mem[i]);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic waitFin(input int budget, input string name);
    int n = 0;
    while (fin !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(fin), 1);
  endtask

  task automatic waitTx(input int target, input string name);
    int n = 0;
    while (txCount < target && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput(name, txCount, target);
  endtask

  task automatic checkDumpEnd(input string name);
    @(negedge clk);
    checkOutput({name, "_fin"}, 32'(fin), 1);
    checkOutput({name, "_addr"}, 32'(Addr), 0);
    checkOutput({name, "_reads_left"}, expAddrQ.size(), 0);
    checkOutput({name, "_bytes_left"}, expByteQ.size(), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int tx0, ren0, sz, disturb;
    logic [AW-1:0] savedAddr;

    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_addr", 32'(Addr), 0);
    checkOutput("reset_ren", 32'(Ren), 0);
    checkOutput("reset_txstart", 32'(Tx_start), 0);
    checkOutput("reset_txdata", 32'(Tx_data), 0);
    checkOutput("reset_fin", 32'(fin), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Four-byte dump with a 10-clock transmitter.
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h00;
    memory_size = 4'd3; txDelay = 0; busyLen = 10;
    tx0 = txCount; ren0 = renCount; sentLog.delete();
    pushExpected(3);
    applyStimulus();
    waitFin(300, "basic_fin");
    checkOutput("basic_nbytes", sentLog.size(), 4);
    if (sentLog.size() == 4) begin
      checkOutput("basic_byte0", 32'(sentLog[0]), 32'h A5);
      checkOutput("basic_byte1", 32'(sentLog[1]), 32'h 3C);
      checkOutput("basic_byte2", 32'(sentLog[2]), 32'h FF);
      checkOutput("basic_byte3", 32'(sentLog[3]), 32'h 00);
    end
    checkOutput("basic_reads", renCount - ren0, 4);
    checkDumpEnd("basic");

    // Single-byte dump.
    mem[0] = 8'h7E; memory_size = 4'd0;
    ren0 = renCount; sentLog.delete();
    pushExpected(0);
    applyStimulus();
    waitFin(100, "single_fin");
    checkOutput("single_reads", renCount - ren0, 1);
    checkOutput("single_nbytes", sentLog.size(), 1);
    if (sentLog.size() == 1) checkOutput("single_byte", 32'(sentLog[0]), 32'h7E);
    checkDumpEnd("single");

    // Late busy: the reader must hold in its acknowledge wait.
    memory_size = 4'd1; txDelay = 3; busyLen = 10;
    tx0 = txCount;
    pushExpected(1);
    applyStimulus();
    waitTx(tx0 + 1, "late_first_tx");
    savedAddr = Addr;
    checkOutput("late_addr0", 32'(savedAddr), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("late_no_txstart", 32'(Tx_start), 0);
      checkOutput("late_addr_hold", 32'(Addr), 32'(savedAddr));
    end
    waitFin(200, "late_fin");
    checkDumpEnd("late");

    // Start pulse and size change while draining must be ignored.
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    memory_size = 4'd3; txDelay = 0; busyLen = 10;
    tx0 = txCount; sentLog.delete();
    pushExpected(3);
    applyStimulus();
    waitTx(tx0 + 1, "ignore_first_tx");
    repeat (3) @(posedge clk);
    #1 start = 1'b1; memory_size = 4'd1;
    @(posedge clk); #1 start = 1'b0;
    waitFin(300, "ignore_fin");
    checkOutput("ignore_nbytes", sentLog.size(), 4);
    checkDumpEnd("ignore");

    // Asynchronous reset during the second byte's acknowledge wait.
    memory_size = 4'd3;
    tx0 = txCount; sentLog.delete();
    pushExpected(3);
    applyStimulus();
    waitTx(tx0 + 2, "abort_second_tx");
    #1 rst = 1'b1;
    #1;
    checkOutput("abort_addr", 32'(Addr), 0);
    checkOutput("abort_ren", 32'(Ren), 0);
    checkOutput("abort_txstart", 32'(Tx_start), 0);
    checkOutput("abort_txdata", 32'(Tx_data), 0);
    checkOutput("abort_fin", 32'(fin), 0);
    expAddrQ.delete(); expByteQ.delete();
    @(posedge clk); #1 rst = 1'b0;
    ren0 = renCount; tx0 = txCount;
    repeat (20) @(negedge clk);
    checkOutput("abort_quiet_ren", renCount - ren0, 0);
    checkOutput("abort_quiet_tx", txCount - tx0, 0);
    sentLog.delete();
    pushExpected(3);
    applyStimulus();
    waitFin(300, "resend_fin");
    checkOutput("resend_nbytes", sentLog.size(), 4);
    checkDumpEnd("resend");

    // Start held high: two back-to-back dumps with a one-clock fin.
    memory_size = 4'd1; txDelay = 0; busyLen = 3;
    sentLog.delete();
    pushExpected(1);
    pushExpected(1);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    waitFin(200, "held_first_fin");
    @(negedge clk);
    checkOutput("held_fin_one_clk", 32'(fin), 0);
    checkOutput("held_restart_ren", 32'(Ren), 1);
    #1 start = 1'b0;
    waitFin(200, "held_second_fin");
    checkOutput("held_nbytes", sentLog.size(), 4);
    checkDumpEnd("held");

    // Random dumps, the first at the largest legal size.
    for (int it = 0; it < 12; it++) begin
      sz = (it == 0) ? 15 : int'($urandom_range(0, 15));
      txDelay = $urandom_range(0, 3);
      busyLen = $urandom_range(1, 12);
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      memory_size = AW'(sz);
      tx0 = txCount; ren0 = renCount;
      pushExpected(sz);
      applyStimulus();
      disturb = $urandom_range(0, 30);
      repeat (disturb) @(posedge clk);
      #1;
      if (fin == 1'b0) begin
        start = 1'b1;
        memory_size = AW'($urandom);
        @(posedge clk); #1 start = 1'b0;
      end
      waitFin((sz + 1) * (busyLen + txDelay + 8) + 40, "rand_fin");
      checkOutput("rand_nbytes", txCount - tx0, sz + 1);
      checkOutput("rand_reads", renCount - ren0, sz + 1);
      checkDumpEnd("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
